// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit
//   Registered bitwise logic unit. Each accepted beat either produces a
//   two-operand result (AND/OR/XOR/NOR) or folds into a multi-beat
//   reduction (AND/OR/XOR) that is terminated by `last`. Results go to a
//   one-entry output register with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   source presents a beat
//   in_ready   unit can accept a beat this cycle
//   a, b       WIDTH-bit operands (b only used by ops 0-3)
//   op         0 AND, 1 OR, 2 XOR, 3 NOR, 4 ACC_AND, 5 ACC_OR, 6 ACC_XOR, 7 reserved
//   last       final beat of an accumulation
//   out_valid  result register holds a result
//   out_ready  consumer takes the result
//   result     registered result
//   beats      number of input beats folded into result (saturating)
//   err        result came from reserved op 7
module logic_reduce_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] beats,
  output logic             err
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [1:0]       acc_fn, acc_fn_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             load;
  logic [WIDTH-1:0] result_nxt;
  logic [CNT_W-1:0] beats_nxt;
  logic             err_nxt;
  logic             accept;

  // The low two op bits select the same function for both families:
  // 0/4 AND, 1/5 OR, 2/6 XOR, 3 NOR (NOR is never latched for accumulation).
  function automatic logic [WIDTH-1:0] bit_op(input logic [1:0] fn,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (fn)
      2'd0:    bit_op = x & y;
      2'd1:    bit_op = x | y;
      2'd2:    bit_op = x ^ y;
      default: bit_op = ~(x | y);
    endcase
  endfunction

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  // A full output register can still accept when it is drained this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    acc_fn_nxt = acc_fn;
    count_nxt  = count;
    load       = 1'b0;
    result_nxt = result;
    beats_nxt  = beats;
    err_nxt    = err;
    if (accept) begin
      case (state)
        IDLE: begin
          if (op == 3'd7) begin
            load       = 1'b1;
            result_nxt = '0;
            beats_nxt  = CNT_W'(1);
            err_nxt    = 1'b1;
          end else if (!op[2]) begin
            load       = 1'b1;
            result_nxt = bit_op(op[1:0], a, b);
            beats_nxt  = CNT_W'(1);
            err_nxt    = 1'b0;
          end else if (last) begin
            // Single-beat reduction: the fold of one operand is itself.
            load       = 1'b1;
            result_nxt = a;
            beats_nxt  = CNT_W'(1);
            err_nxt    = 1'b0;
          end else begin
            state_nxt  = ACCUM;
            acc_nxt    = a;
            acc_fn_nxt = op[1:0];
            count_nxt  = CNT_W'(1);
          end
        end
        ACCUM: begin
          if (last) begin
            load       = 1'b1;
            result_nxt = bit_op(acc_fn, acc, a);
            beats_nxt  = sat_inc(count);
            err_nxt    = 1'b0;
            state_nxt  = IDLE;
            acc_nxt    = '0;
            count_nxt  = '0;
          end else begin
            acc_nxt    = bit_op(acc_fn, acc, a);
            count_nxt  = sat_inc(count);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accumulator and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      acc_fn <= 2'd0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      acc_fn <= acc_fn_nxt;
      count  <= count_nxt;
    end
  end

  // Output register: a new load wins over a drain, so no bubble appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      beats     <= '0;
      err       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= result_nxt;
      beats     <= beats_nxt;
      err       <= err_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_reduce_unit.sv
module tb_logic_reduce_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, err;
  logic [7:0] result, beats;
  logic       s_in_ready, s_out_valid, s_err;
  logic [7:0] s_result;
  logic [1:0] s_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_reduce_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .last(last),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .beats(beats), .err(err));

  logic_reduce_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .last(last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .beats(s_beats), .err(s_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic [7:0] n,
                           input logic e);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".beats"}, 32'(beats), 32'(n));
    check({tag, ".err"}, 32'(err), 32'(e));
  endtask

  initial begin
    // Reset
    #2 reset = 1'b1;
    #20;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.beats", 32'(beats), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Two-operand ops
    in_valid = 1'b1; a = 8'hF0; b = 8'h3C; last = 1'b0;
    op = 3'd0; step(); check_out("and", 8'h30, 8'd1, 1'b0);
    op = 3'd1; step(); check_out("or",  8'hFC, 8'd1, 1'b0);
    op = 3'd2; step(); check_out("xor", 8'hCC, 8'd1, 1'b0);
    op = 3'd3; step(); check_out("nor", 8'h03, 8'd1, 1'b0);
    in_valid = 1'b0; step();
    check("drain.valid", 32'(out_valid), 32'd0);

    // XOR accumulation over four beats
    in_valid = 1'b1; op = 3'd6; b = 8'hFF;
    a = 8'h01; step(); check("acc1.valid", 32'(out_valid), 32'd0);
    a = 8'h02; op = 3'd0; step(); check("acc2.valid", 32'(out_valid), 32'd0);
    a = 8'h04; op = 3'd3; step(); check("acc3.valid", 32'(out_valid), 32'd0);
    a = 8'h80; last = 1'b1; step(); check_out("accx", 8'h87, 8'd4, 1'b0);
    in_valid = 1'b0; last = 1'b0; step();
    check("accx.once", 32'(out_valid), 32'd0);

    // Backpressure: hold a result, stall a second beat, then release
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd1; a = 8'h0F; b = 8'hF0;
    step(); check_out("bp.first", 8'hFF, 8'd1, 1'b0);
    op = 3'd0; a = 8'hAA; b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      check("bp.in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp.hold", 32'(result), 32'hFF);
      check("bp.hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    step(); check_out("bp.second", 8'h0A, 8'd1, 1'b0);
    in_valid = 1'b0; step();
    check("bp.drain", 32'(out_valid), 32'd0);

    // AND accumulation of six beats; the 2-bit counter must saturate at 3
    in_valid = 1'b1; op = 3'd4; a = 8'hFF; last = 1'b0;
    for (int i = 0; i < 5; i++) step();
    last = 1'b1; step();
    check("sat.valid", 32'(s_out_valid), 32'd1);
    check("sat.result", 32'(s_result), 32'hFF);
    check("sat.beats", 32'(s_beats), 32'd3);
    check("sat.wide_beats", 32'(beats), 32'd6);
    in_valid = 1'b0; last = 1'b0; step();

    // Reserved op, then a single-beat reduction
    in_valid = 1'b1; op = 3'd7; a = 8'h12; b = 8'h34;
    step(); check_out("rsvd", 8'h00, 8'd1, 1'b1);
    op = 3'd5; a = 8'h5A; last = 1'b1;
    step(); check_out("single", 8'h5A, 8'd1, 1'b0);
    in_valid = 1'b0; last = 1'b0; step();

    // Async reset in the middle of an accumulation
    in_valid = 1'b1; op = 3'd4; a = 8'hF0;
    step(); step();
    in_valid = 1'b0;
    check("pre_rst.result", 32'(result), 32'h5A);
    #2 reset = 1'b1; #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.result", 32'(result), 32'd0);
    check("arst.beats", 32'(beats), 32'd0);
    #1 reset = 1'b0;
    step();
    in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h0F;
    step(); check_out("post_rst", 8'h0F, 8'd1, 1'b0);
    op = 3'd6; a = 8'h3C; step();
    a = 8'h0F; last = 1'b1; step(); check_out("post_acc", 8'h33, 8'd2, 1'b0);
    in_valid = 1'b0; last = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
